// File: rtl/ysyx_23060059_axi_arbiter.sv
// AXI4 arbiter merging the I-cache read master (M0) and the D-cache master (M1)
// onto one SoC master port; reads are round-robin and locked per burst, writes are M1-only.
module ysyx_23060059_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  // M0: instruction-cache read master
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  output logic [ID_W-1:0]     m0_rid,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  // M1: data-cache master
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rlast,
  output logic [ID_W-1:0]     m1_rid,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic [ID_W-1:0]     m1_bid,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // S: toward the SoC crossbar
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  input  logic [ID_W-1:0]     s_rid,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic [ID_W-1:0]     s_bid,
  input  logic                s_bvalid,
  output logic                s_bready
);

  localparam logic [2:0] R_IDLE = 3'd0;
  localparam logic [2:0] R_AR0  = 3'd1;
  localparam logic [2:0] R_R0   = 3'd2;
  localparam logic [2:0] R_AR1  = 3'd3;
  localparam logic [2:0] R_R1   = 3'd4;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  logic [2:0] r_rstate;
  logic [2:0] w_rstate_nxt;
  logic       r_last_grant;
  logic       w_last_grant_nxt;
  logic [1:0] r_wstate;
  logic [1:0] w_wstate_nxt;
  logic       r_w_busy;
  logic       w_w_busy_nxt;
  logic       r_aw_done;
  logic       w_aw_done_nxt;
  logic       r_w_done;
  logic       w_w_done_nxt;

  logic       w_wr_start;
  logic       w_req0;
  logic       w_req1;
  logic       w_aw_hs;
  logic       w_wlast_hs;

  // A new write claims the idle cycle, so a same-cycle M1 read is held off and
  // then stays blocked by w_busy until the write response completes.
  assign w_wr_start = (r_wstate == W_IDLE) && m1_awvalid &&
                      (r_rstate != R_AR1) && (r_rstate != R_R1);
  assign w_req0     = m0_arvalid;
  assign w_req1     = m1_arvalid && !r_w_busy && (r_wstate == W_IDLE) && !w_wr_start;
  assign w_aw_hs    = m1_awvalid && s_awready;
  assign w_wlast_hs = m1_wvalid && !r_w_done && s_wready && m1_wlast;

  always_comb begin
    w_rstate_nxt     = r_rstate;
    w_last_grant_nxt = r_last_grant;
    case (r_rstate)
      R_IDLE: begin
        if (w_req0 && w_req1) begin
          if (r_last_grant) begin
            w_rstate_nxt     = R_AR0;
            w_last_grant_nxt = 1'b0;
          end else begin
            w_rstate_nxt     = R_AR1;
            w_last_grant_nxt = 1'b1;
          end
        end else if (w_req0) begin
          w_rstate_nxt     = R_AR0;
          w_last_grant_nxt = 1'b0;
        end else if (w_req1) begin
          w_rstate_nxt     = R_AR1;
          w_last_grant_nxt = 1'b1;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_AR0: begin
        if (m0_arvalid && s_arready) w_rstate_nxt = R_R0;
        else w_rstate_nxt = R_AR0;
      end
      R_R0: begin
        if (s_rvalid && m0_rready && s_rlast) w_rstate_nxt = R_IDLE;
        else w_rstate_nxt = R_R0;
      end
      R_AR1: begin
        if (m1_arvalid && s_arready) w_rstate_nxt = R_R1;
        else w_rstate_nxt = R_AR1;
      end
      R_R1: begin
        if (s_rvalid && m1_rready && s_rlast) w_rstate_nxt = R_IDLE;
        else w_rstate_nxt = R_R1;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_w_busy_nxt  = r_w_busy;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    case (r_wstate)
      W_IDLE: begin
        if (w_wr_start) begin
          w_wstate_nxt  = W_ADDR;
          w_w_busy_nxt  = 1'b1;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_ADDR: begin
        w_aw_done_nxt = r_aw_done || w_aw_hs;
        w_w_done_nxt  = r_w_done || w_wlast_hs;
        if (w_aw_done_nxt && w_w_done_nxt) w_wstate_nxt = W_RESP;
        else if (w_aw_done_nxt) w_wstate_nxt = W_DATA;
        else w_wstate_nxt = W_ADDR;
      end
      W_DATA: begin
        if (m1_wvalid && s_wready && m1_wlast) begin
          w_wstate_nxt = W_RESP;
          w_w_done_nxt = 1'b1;
        end else begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_RESP: begin
        if (s_bvalid && m1_bready) begin
          w_wstate_nxt = W_IDLE;
          w_w_busy_nxt = 1'b0;
        end else begin
          w_wstate_nxt = W_RESP;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rstate     <= R_IDLE;
      r_last_grant <= 1'b1;
      r_wstate     <= W_IDLE;
      r_w_busy     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
    end else begin
      r_rstate     <= w_rstate_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_wstate     <= w_wstate_nxt;
      r_w_busy     <= w_w_busy_nxt;
      r_aw_done    <= w_aw_done_nxt;
      r_w_done     <= w_w_done_nxt;
    end
  end

  // Read-side routing: everything not owned by the current grant is driven to zero.
  always_comb begin
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = 8'd0;
    s_arsize   = 3'd0;
    s_arburst  = 2'd0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = 2'd0;
    m0_rlast   = 1'b0;
    m0_rid     = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = 2'd0;
    m1_rlast   = 1'b0;
    m1_rid     = '0;
    m1_rvalid  = 1'b0;
    case (r_rstate)
      R_AR0: begin
        s_araddr   = m0_araddr;
        s_arid     = m0_arid;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
      end
      R_R0: begin
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        m0_rid    = s_rid;
        m0_rvalid = s_rvalid;
        s_rready  = m0_rready;
      end
      R_AR1: begin
        s_araddr   = m1_araddr;
        s_arid     = m1_arid;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
      end
      R_R1: begin
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        m1_rid    = s_rid;
        m1_rvalid = s_rvalid;
        s_rready  = m1_rready;
      end
      default: begin
        s_arvalid = 1'b0;
      end
    endcase
  end

  // Write-side routing; once wlast has been accepted in W_ADDR the W channel is closed.
  always_comb begin
    s_awaddr   = '0;
    s_awid     = '0;
    s_awlen    = 8'd0;
    s_awsize   = 3'd0;
    s_awburst  = 2'd0;
    s_awvalid  = 1'b0;
    m1_awready = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_wvalid   = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = 2'd0;
    m1_bid     = '0;
    m1_bvalid  = 1'b0;
    s_bready   = 1'b0;
    case (r_wstate)
      W_ADDR: begin
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        s_awvalid  = m1_awvalid;
        m1_awready = s_awready;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        s_wvalid   = m1_wvalid && !r_w_done;
        m1_wready  = s_wready && !r_w_done;
      end
      W_DATA: begin
        s_wdata   = m1_wdata;
        s_wstrb   = m1_wstrb;
        s_wlast   = m1_wlast;
        s_wvalid  = m1_wvalid;
        m1_wready = s_wready;
      end
      W_RESP: begin
        m1_bresp  = s_bresp;
        m1_bid    = s_bid;
        m1_bvalid = s_bvalid;
        s_bready  = m1_bready;
      end
      default: begin
        s_awvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060059_axi_arbiter.sv
// Directed self-checking bench for ysyx_23060059_axi_arbiter.
module tb_ysyx_23060059_axi_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] m0_araddr;  logic [3:0] m0_arid;  logic [7:0] m0_arlen;
  logic [2:0]  m0_arsize;  logic [1:0] m0_arburst; logic m0_arvalid; logic m0_arready;
  logic [63:0] m0_rdata;   logic [1:0] m0_rresp; logic m0_rlast; logic [3:0] m0_rid;
  logic        m0_rvalid;  logic m0_rready;
  logic [31:0] m1_araddr;  logic [3:0] m1_arid;  logic [7:0] m1_arlen;
  logic [2:0]  m1_arsize;  logic [1:0] m1_arburst; logic m1_arvalid; logic m1_arready;
  logic [63:0] m1_rdata;   logic [1:0] m1_rresp; logic m1_rlast; logic [3:0] m1_rid;
  logic        m1_rvalid;  logic m1_rready;
  logic [31:0] m1_awaddr;  logic [3:0] m1_awid;  logic [7:0] m1_awlen;
  logic [2:0]  m1_awsize;  logic [1:0] m1_awburst; logic m1_awvalid; logic m1_awready;
  logic [63:0] m1_wdata;   logic [7:0] m1_wstrb; logic m1_wlast; logic m1_wvalid; logic m1_wready;
  logic [1:0]  m1_bresp;   logic [3:0] m1_bid;   logic m1_bvalid; logic m1_bready;
  logic [31:0] s_araddr;   logic [3:0] s_arid;   logic [7:0] s_arlen;
  logic [2:0]  s_arsize;   logic [1:0] s_arburst; logic s_arvalid; logic s_arready;
  logic [63:0] s_rdata;    logic [1:0] s_rresp;  logic s_rlast; logic [3:0] s_rid;
  logic        s_rvalid;   logic s_rready;
  logic [31:0] s_awaddr;   logic [3:0] s_awid;   logic [7:0] s_awlen;
  logic [2:0]  s_awsize;   logic [1:0] s_awburst; logic s_awvalid; logic s_awready;
  logic [63:0] s_wdata;    logic [7:0] s_wstrb;  logic s_wlast; logic s_wvalid; logic s_wready;
  logic [1:0]  s_bresp;    logic [3:0] s_bid;    logic s_bvalid; logic s_bready;

  int checks   = 0;
  int failures = 0;

  ysyx_23060059_axi_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
    .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
    .m1_wready(m1_wready), .m1_bresp(m1_bresp), .m1_bid(m1_bid), .m1_bvalid(m1_bvalid),
    .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bresp(s_bresp), .s_bid(s_bid), .s_bvalid(s_bvalid),
    .s_bready(s_bready)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m0_araddr = 32'd0; m0_arid = 4'd0; m0_arlen = 8'd0; m0_arsize = 3'd3; m0_arburst = 2'd1;
    m0_arvalid = 1'b0; m0_rready = 1'b0;
    m1_araddr = 32'd0; m1_arid = 4'd0; m1_arlen = 8'd0; m1_arsize = 3'd3; m1_arburst = 2'd1;
    m1_arvalid = 1'b0; m1_rready = 1'b0;
    m1_awaddr = 32'd0; m1_awid = 4'd0; m1_awlen = 8'd0; m1_awsize = 3'd3; m1_awburst = 2'd1;
    m1_awvalid = 1'b0; m1_wdata = 64'd0; m1_wstrb = 8'd0; m1_wlast = 1'b0; m1_wvalid = 1'b0;
    m1_bready = 1'b0;
    s_arready = 1'b0; s_rdata = 64'd0; s_rresp = 2'd0; s_rlast = 1'b0; s_rid = 4'd0;
    s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_bresp = 2'd0; s_bid = 4'd0; s_bvalid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_s_awvalid", 64'(s_awvalid), 64'd0);
    chk("rst_s_rready",  64'(s_rready),  64'd0);
    chk("rst_m1_bvalid", 64'(m1_bvalid), 64'd0);
    chk("rst_last_grant", 64'(dut.r_last_grant), 64'd1);

    // M0 single-beat read
    m0_araddr = 32'h8000_0000; m0_arid = 4'd1; m0_arvalid = 1'b1;
    #1;
    chk("m0_grant_latency", 64'(s_arvalid), 64'd0);
    tick();
    chk("m0_s_arvalid", 64'(s_arvalid), 64'd1);
    chk("m0_s_araddr",  64'(s_araddr),  64'h8000_0000);
    chk("m0_s_arid",    64'(s_arid),    64'd1);
    chk("m1_arready_off", 64'(m1_arready), 64'd0);
    s_arready = 1'b1;
    #1;
    chk("m0_arready", 64'(m0_arready), 64'd1);
    tick();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rdata = 64'h1122_3344_5566_7788; s_rlast = 1'b1; s_rvalid = 1'b1; s_rid = 4'd1;
    m0_rready = 1'b1;
    #1;
    chk("m0_rvalid", 64'(m0_rvalid), 64'd1);
    chk("m0_rdata",  m0_rdata,       64'h1122_3344_5566_7788);
    chk("m0_rlast",  64'(m0_rlast),  64'd1);
    chk("m1_rvalid_quiet", 64'(m1_rvalid), 64'd0);
    chk("m1_rdata_zero",   m1_rdata,       64'd0);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk("m0_done_rready", 64'(s_rready), 64'd0);
    chk("m0_done_state",  64'(dut.r_rstate), 64'd0);

    // Round-robin with both masters held requesting
    do_reset();
    m0_araddr = 32'h8000_1000; m1_araddr = 32'h8000_2000;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
    s_rvalid = 1'b1; s_rlast = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic e1;
      e1 = i[0];
      s_rdata = 64'hA0 + 64'(i);
      #1;
      chk("rr_idle_arvalid", 64'(s_arvalid), 64'd0);
      tick();
      chk("rr_s_araddr", 64'(s_araddr), e1 ? 64'h8000_2000 : 64'h8000_1000);
      chk("rr_m0_arready", 64'(m0_arready), e1 ? 64'd0 : 64'd1);
      chk("rr_m1_arready", 64'(m1_arready), e1 ? 64'd1 : 64'd0);
      tick();
      chk("rr_m0_rvalid", 64'(m0_rvalid), e1 ? 64'd0 : 64'd1);
      chk("rr_m1_rvalid", 64'(m1_rvalid), e1 ? 64'd1 : 64'd0);
      chk("rr_beat_data", e1 ? m1_rdata : m0_rdata, 64'hA0 + 64'(i));
      tick();
    end
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;

    // M1 write, W before AW, with a same-cycle M1 read request held off
    do_reset();
    m1_awaddr = 32'h8000_0010; m1_awid = 4'd2; m1_awvalid = 1'b1;
    m1_wdata = 64'hDEAD_BEEF_0BAD_F00D; m1_wstrb = 8'hF0; m1_wlast = 1'b1; m1_wvalid = 1'b1;
    s_wready = 1'b1; m1_bready = 1'b1;
    m1_araddr = 32'h8000_0010; m1_arid = 4'd3; m1_arvalid = 1'b1;
    #1;
    chk("wr_idle_awvalid", 64'(s_awvalid), 64'd0);
    tick();
    chk("wr_s_awvalid", 64'(s_awvalid), 64'd1);
    chk("wr_s_awaddr",  64'(s_awaddr),  64'h8000_0010);
    chk("wr_s_wvalid",  64'(s_wvalid),  64'd1);
    chk("wr_s_wstrb",   64'(s_wstrb),   64'hF0);
    chk("wr_s_wdata",   s_wdata,        64'hDEAD_BEEF_0BAD_F00D);
    chk("wr_m1_awready_low", 64'(m1_awready), 64'd0);
    chk("wr_ar_blocked", 64'(s_arvalid), 64'd0);
    tick();
    m1_wvalid = 1'b0;
    #1;
    chk("wr_wdone_state",  64'(dut.r_wstate), 64'd1);
    chk("wr_wdone_wvalid", 64'(s_wvalid), 64'd0);
    chk("wr_wdone_wready", 64'(m1_wready), 64'd0);
    s_awready = 1'b1;
    #1;
    chk("wr_m1_awready", 64'(m1_awready), 64'd1);
    tick();
    m1_awvalid = 1'b0; s_awready = 1'b0;
    #1;
    chk("wr_resp_state",   64'(dut.r_wstate), 64'd3);
    chk("wr_resp_bready",  64'(s_bready),  64'd1);
    chk("wr_resp_bvalid0", 64'(m1_bvalid), 64'd0);
    chk("wr_resp_ar_blocked", 64'(s_arvalid), 64'd0);
    s_bvalid = 1'b1; s_bid = 4'd2;
    #1;
    chk("wr_m1_bvalid", 64'(m1_bvalid), 64'd1);
    chk("wr_m1_bid",    64'(m1_bid),    64'd2);
    tick();
    s_bvalid = 1'b0;
    #1;
    chk("wr_bvalid_once", 64'(m1_bvalid), 64'd0);
    chk("wr_ar_still_idle", 64'(s_arvalid), 64'd0);
    tick();
    chk("wr_then_m1_arvalid", 64'(s_arvalid), 64'd1);
    chk("wr_then_m1_araddr",  64'(s_araddr),  64'h8000_0010);
    s_arready = 1'b1;
    tick();
    m1_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rresp = 2'd2; s_rdata = 64'hCAFE; m1_rready = 1'b1;
    #1;
    chk("m1_rresp_slverr", 64'(m1_rresp), 64'd2);
    chk("m1_rvalid",       64'(m1_rvalid), 64'd1);
    chk("m1_rdata",        m1_rdata,       64'hCAFE);
    chk("m0_rvalid_quiet", 64'(m0_rvalid), 64'd0);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'd0;
    #1;
    chk("slverr_back_idle", 64'(dut.r_rstate), 64'd0);

    // M0 4-beat burst locks out a pending M1 read
    m0_araddr = 32'h8000_0100; m0_arlen = 8'd3; m0_arvalid = 1'b1;
    m1_araddr = 32'h8000_0200; m1_arvalid = 1'b1; s_arready = 1'b1; m0_rready = 1'b1;
    tick();
    chk("burst_s_araddr", 64'(s_araddr), 64'h8000_0100);
    chk("burst_s_arlen",  64'(s_arlen),  64'd3);
    tick();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1; s_rlast = (b == 3); s_rdata = 64'h100 + 64'(b);
      #1;
      chk("burst_m0_rdata", m0_rdata, 64'h100 + 64'(b));
      chk("burst_m1_rvalid", 64'(m1_rvalid), 64'd0);
      chk("burst_m1_withheld", 64'(s_arvalid), 64'd0);
      tick();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk("post_burst_idle_arvalid", 64'(s_arvalid), 64'd0);
    tick();
    chk("post_burst_m1_arvalid", 64'(s_arvalid), 64'd1);
    chk("post_burst_m1_araddr",  64'(s_araddr),  64'h8000_0200);
    s_arready = 1'b1;
    tick();
    m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b0;
    #1;
    chk("r1_mid_rvalid", 64'(m1_rvalid), 64'd1);

    // Reset in R_R1 with s_rvalid still high
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_m1_rvalid", 64'(m1_rvalid), 64'd0);
    chk("midrst_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("midrst_m1_bvalid", 64'(m1_bvalid), 64'd0);
    chk("midrst_s_rready",  64'(s_rready),  64'd0);
    chk("midrst_rstate",    64'(dut.r_rstate), 64'd0);
    chk("midrst_wstate",    64'(dut.r_wstate), 64'd0);
    chk("midrst_last_grant", 64'(dut.r_last_grant), 64'd1);
    s_rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
